// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int          XLEN          = 32;
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic op_signed_a(input op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_signed_b(input op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] x);
      return neg ? (~x + 32'd1) : x;
   endfunction

   function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] x);
      return neg ? (~x + 64'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add / restoring-divide steps
// on operand magnitudes, then one sign/special-case fix-up cycle.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   import muldiv_pkg::*;

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opd_q, opd_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic                neg_a_q, neg_a_d;
   logic                neg_b_q, neg_b_d;
   logic                b_zero_q, b_zero_d;
   logic                ovf_q, ovf_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   op_e                 in_op;
   logic                in_neg_a, in_neg_b, in_is_mul;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                is_mul;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next, div_next;
   logic [XLEN:0]       div_part;
   logic [XLEN-1:0]     div_rem;
   logic [2*XLEN-1:0]   prod_s;
   logic [XLEN-1:0]     quot_s, rem_s, final_val;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (cnt_q == CNT_W'(XLEN-1)) state_d = FINAL;
         FINAL:   state_d = DONE;
         DONE:    state_d = start ? CALC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the upcoming state so they are registered.
   always_comb begin
      busy_d = (state_d == CALC) || (state_d == FINAL);
      done_d = (state_d == DONE);
   end

   always_comb begin
      in_op     = op_e'(funct3);
      in_neg_a  = op_signed_a(in_op) && rs1_val[XLEN-1];
      in_neg_b  = op_signed_b(in_op) && rs2_val[XLEN-1];
      in_is_mul = ~funct3[2];
      mag_a     = cond_neg32(in_neg_a, rs1_val);
      mag_b     = cond_neg32(in_neg_b, rs2_val);
   end

   // One iteration step. Multiply shifts right with the multiplier in the low
   // half; divide shifts left with the dividend in the low half.
   always_comb begin
      is_mul   = ~op_q[2];
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opd_q : '0)};
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      div_part = acc_q[2*XLEN-1:XLEN-1];
      div_rem  = div_part[XLEN-1:0] - opd_q;
      div_next = (div_part >= {1'b0, opd_q}) ? {div_rem, acc_q[XLEN-2:0], 1'b1}
                                             : {acc_q[2*XLEN-2:0], 1'b0};
   end

   always_comb begin
      prod_s = cond_neg64(neg_a_q ^ neg_b_q, acc_q);
      quot_s = cond_neg32(neg_a_q ^ neg_b_q, acc_q[XLEN-1:0]);
      rem_s  = cond_neg32(neg_a_q, acc_q[2*XLEN-1:XLEN]);
      unique case (op_q)
         OP_MUL:    final_val = prod_s[XLEN-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  final_val = prod_s[2*XLEN-1:XLEN];
         OP_DIV:    final_val = b_zero_q ? DIV_BY_ZERO_Q : (ovf_q ? INT_MIN : quot_s);
         OP_DIVU:   final_val = b_zero_q ? DIV_BY_ZERO_Q : acc_q[XLEN-1:0];
         OP_REM:    final_val = b_zero_q ? a_q : (ovf_q ? '0 : rem_s);
         OP_REMU:   final_val = b_zero_q ? a_q : acc_q[2*XLEN-1:XLEN];
         default:   final_val = '0;
      endcase
   end

   always_comb begin
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      a_d      = a_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      b_zero_d = b_zero_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               op_d     = in_op;
               cnt_d    = '0;
               acc_d    = {{XLEN{1'b0}}, (in_is_mul ? mag_b : mag_a)};
               opd_d    = in_is_mul ? mag_a : mag_b;
               a_d      = rs1_val;
               neg_a_d  = in_neg_a;
               neg_b_d  = in_neg_b;
               b_zero_d = (rs2_val == '0);
               ovf_d    = (rs1_val == INT_MIN) && (rs2_val == '1);
            end
         end
         CALC: begin
            acc_d = is_mul ? mul_next : div_next;
            cnt_d = cnt_q + 1'b1;
         end
         FINAL:   result_d = final_val;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= OP_MUL;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         a_q      <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         b_zero_q <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         a_q      <= a_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         b_zero_q <= b_zero_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at start, compared at done.
module tb_muldiv_unit;

   localparam int LAT     = 33;
   localparam int TIMEOUT = 60;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic        busy, done;
   logic [31:0] result;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;
   int issue_cyc = 0;
   logic [31:0] sb_q[$];

   muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Drive one request in the current cycle; returns #1 after the accepting edge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      funct3  = f;
      rs1_val = a;
      rs2_val = b;
      start   = 1'b1;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      issue_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      int n;
      n = 0;
      while (!done && n < TIMEOUT) begin
         @(posedge clk);
         #1;
         n++;
      end
      lat = done ? (cyc - issue_cyc) : -1;
   endtask

   task automatic test_reset;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
      total_cnt++;
      if (result !== 32'h0) $display("FAIL reset_result got=%h want=00000000", result); else pass_cnt++;
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      $display("txn reset released busy=%b done=%b result=%h", busy, done, result);
   endtask

   task automatic test_mul_basic;
      int lat;
      logic [31:0] exp;
      issue(3'd0, 32'd7, 32'd6, 32'h0000_002A);
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL mul_busy_first got=%b want=1", busy); else pass_cnt++;
      repeat (31) @(posedge clk);
      #1;
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL mul_busy_final got=%b/%b want=1/0", busy, done);
      else pass_cnt++;
      wait_done(lat);
      exp = sb_q.pop_front();
      $display("txn MUL 7*6 result=%h latency=%0d", result, lat);
      total_cnt++;
      if (lat !== LAT) $display("FAIL mul_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
      total_cnt++;
      if (result !== exp) $display("FAIL mul_result got=%h want=%h", result, exp); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL mul_busy_at_done got=%b want=0", busy); else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL mul_done_pulse got=%b want=0", done); else pass_cnt++;
      total_cnt++;
      if (result !== exp) $display("FAIL mul_result_hold got=%h want=%h", result, exp); else pass_cnt++;
   endtask

   // Fixed vectors: MULH family, signed/unsigned divide, special cases.
   task automatic test_vectors;
      logic [2:0]  f_t[12] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd6, 3'd4, 3'd6, 3'd5};
      logic [31:0] a_t[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'd9};
      logic [31:0] b_t[12] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] e_t[12] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
      int lat;
      logic [31:0] exp;
      for (int i = 0; i < 12; i++) begin
         issue(f_t[i], a_t[i], b_t[i], e_t[i]);
         wait_done(lat);
         exp = sb_q.pop_front();
         $display("txn vec%0d f=%0d a=%h b=%h result=%h latency=%0d", i, f_t[i], a_t[i], b_t[i], result, lat);
         total_cnt++;
         if (lat !== LAT) $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, LAT); else pass_cnt++;
         total_cnt++;
         if (result !== exp) $display("FAIL vec%0d_result got=%h want=%h", i, result, exp); else pass_cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_random;
      int lat;
      logic [2:0]  f;
      logic [31:0] a, b, exp;
      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 6 == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
         issue(f, a, b, model(f, a, b));
         wait_done(lat);
         exp = sb_q.pop_front();
         $display("txn rnd%0d f=%0d a=%h b=%h result=%h", i, f, a, b, result);
         total_cnt++;
         if (lat !== LAT || result !== exp)
            $display("FAIL rnd%0d got=%h lat=%0d want=%h lat=%0d", i, result, lat, exp, LAT);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [31:0] exp1, exp2;
      issue(3'd0, 32'd100, 32'd3, 32'd300);
      repeat (4) @(posedge clk);
      funct3  = 3'd5;
      rs1_val = 32'd9;
      rs2_val = 32'd3;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      exp1 = sb_q.pop_front();
      $display("txn ignored-start MUL 100*3 result=%h latency=%0d", result, lat);
      total_cnt++;
      if (lat !== LAT) $display("FAIL b2b_first_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
      total_cnt++;
      if (result !== exp1) $display("FAIL b2b_first_result got=%h want=%h", result, exp1); else pass_cnt++;
      // Start held during the done cycle is accepted.
      issue(3'd5, 32'd1000, 32'd10, 32'd100);
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL b2b_accept got=%b/%b want=1/0", busy, done);
      else pass_cnt++;
      repeat (10) @(posedge clk);
      #1;
      total_cnt++;
      if (result !== exp1) $display("FAIL b2b_result_hold got=%h want=%h", result, exp1); else pass_cnt++;
      wait_done(lat);
      exp2 = sb_q.pop_front();
      $display("txn back-to-back DIVU 1000/10 result=%h latency=%0d", result, lat);
      total_cnt++;
      if (lat !== LAT) $display("FAIL b2b_second_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
      total_cnt++;
      if (result !== exp2) $display("FAIL b2b_second_result got=%h want=%h", result, exp2); else pass_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midop;
      int lat;
      int seen;
      logic [31:0] exp;
      issue(3'd1, 32'h1234_5678, 32'h8765_4321, 32'h0);
      void'(sb_q.pop_back());
      repeat (9) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      $display("txn reset mid-op busy=%b done=%b result=%h", busy, done, result);
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL midrst_flags got=%b/%b want=0/0", busy, done);
      else pass_cnt++;
      total_cnt++;
      if (result !== 32'h0) $display("FAIL midrst_result got=%h want=00000000", result); else pass_cnt++;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      total_cnt++;
      if (seen !== 0) $display("FAIL midrst_no_done got=%0d want=0", seen); else pass_cnt++;
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      wait_done(lat);
      exp = sb_q.pop_front();
      $display("txn post-reset DIV -7/2 result=%h latency=%0d", result, lat);
      total_cnt++;
      if (lat !== LAT || result !== exp)
         $display("FAIL midrst_fresh got=%h lat=%0d want=%h lat=%0d", result, lat, exp, LAT);
      else pass_cnt++;
   endtask

   initial begin
      #1;
      test_reset();
      test_mul_basic();
      test_vectors();
      test_random();
      test_back_to_back();
      test_reset_midop();
      total_cnt++;
      if (sb_q.size() !== 0) $display("FAIL scoreboard_empty got=%0d want=0", sb_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
